// File: rtl/uart_pkg.sv
// Shared definitions for the UART echo blocks: ASCII constants, mode-bit
// positions, TX state encoding and the case-folding helper.
package uart_pkg;

  localparam logic [7:0] CHAR_CR     = 8'h0D;
  localparam logic [7:0] CHAR_LF     = 8'h0A;
  localparam logic [7:0] CHAR_A_LO   = 8'h61;
  localparam logic [7:0] CHAR_Z_LO   = 8'h7A;
  localparam logic [7:0] CASE_OFFSET = 8'h20;

  // Bit positions inside the 2-bit mode input
  localparam int MODE_UPCASE = 0;
  localparam int MODE_CRLF   = 1;

  typedef enum logic [1:0] {
    TX_IDLE    = 2'd0,
    TX_HOLD    = 2'd1,
    TX_SEND_LF = 2'd2
  } tx_state_t;

  // Fold a-z to A-Z when enabled; every other byte passes through untouched
  function automatic logic [7:0] upcase(input logic [7:0] b, input logic en);
    logic [7:0] r;
    r = b;
    if (en && (b >= CHAR_A_LO) && (b <= CHAR_Z_LO)) begin
      r = b - CASE_OFFSET;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_echo_fifo_sync_fifo.sv
// Generic single-clock first-word-fallthrough FIFO. Occupancy is kept as an
// explicit counter so full/empty never need an extra pointer bit. A push into
// a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    level_reg;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (level_reg == '0);
  assign full    = (level_reg == LW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Head of queue is visible combinationally (fall-through)
  assign dout  = mem[rd_ptr_reg];
  assign level = level_reg;

  // Storage array: no reset, contents are invalidated by the pointers
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_echo_fifo.sv
// Buffered UART echo: drains buart receive strobes into a FIFO and replays
// them through the transmitter, optionally upper-casing and expanding CR to
// CR LF. Bytes arriving at a full FIFO are dropped and counted.
module uart_echo_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int TX_HOLDOFF = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  output logic                   uart_rd,
  input  logic                   tx_busy,
  output logic                   uart_wr,
  output logic [7:0]             tx_data,
  input  logic [1:0]             mode,
  input  logic                   tx_enable,
  input  logic                   ovf_clr,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow,
  output logic [7:0]             ovf_count
);

  // Counter spans 0..TX_HOLDOFF-1; keep at least one bit for TX_HOLDOFF=1
  localparam int HW = (TX_HOLDOFF > 1) ? $clog2(TX_HOLDOFF) : 1;

  logic            rx_hold_reg;
  logic            rx_take;
  logic            rx_drop;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [7:0]      fifo_dout;
  tx_state_t       state_reg;
  logic [HW-1:0]   hold_cnt_reg;
  logic            lf_pend_reg;

  // rx_valid is only trusted when we did not just strobe uart_rd
  assign rx_take  = rx_valid && !rx_hold_reg;
  assign fifo_pop = (state_reg == TX_IDLE) && !fifo_empty && tx_enable && !tx_busy;
  // A full FIFO still accepts the byte if a slot frees up this same cycle
  assign rx_drop  = rx_take && fifo_full && !fifo_pop;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_take),
    .pop   (fifo_pop),
    .din   (rx_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Receive handshake: one-cycle read strobe followed by a one-cycle blind spot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      uart_rd     <= 1'b0;
      rx_hold_reg <= 1'b0;
    end else begin
      uart_rd     <= rx_take;
      rx_hold_reg <= rx_take;
    end
  end

  // Drop accounting; a clear beats a simultaneous drop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      ovf_count <= 8'd0;
    end else if (ovf_clr) begin
      overflow  <= 1'b0;
      ovf_count <= 8'd0;
    end else if (rx_drop) begin
      overflow <= 1'b1;
      if (ovf_count != 8'hFF) begin
        ovf_count <= ovf_count + 8'd1;
      end
    end
  end

  // Transmit sequencer: pop/transform, wait out the busy-flag lag, append LF
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= TX_IDLE;
      hold_cnt_reg <= '0;
      lf_pend_reg  <= 1'b0;
      uart_wr      <= 1'b0;
      tx_data      <= 8'd0;
    end else begin
      uart_wr <= 1'b0;
      case (state_reg)
        TX_IDLE: begin
          if (fifo_pop) begin
            tx_data      <= upcase(fifo_dout, mode[MODE_UPCASE]);
            uart_wr      <= 1'b1;
            lf_pend_reg  <= mode[MODE_CRLF] && (fifo_dout == CHAR_CR);
            hold_cnt_reg <= '0;
            state_reg    <= TX_HOLD;
          end
        end
        TX_HOLD: begin
          if (hold_cnt_reg == HW'(TX_HOLDOFF - 1)) begin
            state_reg <= lf_pend_reg ? TX_SEND_LF : TX_IDLE;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + HW'(1);
          end
        end
        TX_SEND_LF: begin
          // tx_enable deliberately ignored so a started CR LF pair completes
          if (!tx_busy) begin
            tx_data      <= CHAR_LF;
            uart_wr      <= 1'b1;
            lf_pend_reg  <= 1'b0;
            hold_cnt_reg <= '0;
            state_reg    <= TX_HOLD;
          end
        end
        default: begin
          state_reg <= TX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_echo_fifo.md
# uart_echo_fifo

Buffered, mode-selectable successor to the single-character UART loopback controller. It sits between the `buart` receive/transmit strobe interface and nothing else. Received bytes are drained into a DEPTH-entry FIFO and retransmitted as the transmitter frees up, optionally upper-cased and/or with CR expanded to CR LF. Overflow is counted rather than stalling the receiver.

## Interface
Parameters:
- DEPTH, 16: FIFO entries; power of two, ≥2.
- TX_HOLDOFF, 2: cycles after a `uart_wr` pulse during which `tx_busy` is ignored, covering the `buart` busy-flag lag; ≥1.

Ports:
- clk  in  1  system clock (60 MHz in the loopback project).
- reset  in  1  asynchronous, active-high reset.
- rx_valid  in  1  `buart` has a received byte.
- rx_data  in  8  `buart` received byte.
- uart_rd  out  1  one-cycle read strobe to `buart`.
- tx_busy  in  1  `buart` transmitter busy.
- uart_wr  out  1  one-cycle write strobe to `buart`.
- tx_data  out  8  byte to transmit; stable while `uart_wr` is high and until the next write.
- mode  in  2  bit0 = upper-case a–z; bit1 = CR→CR LF expansion.
- tx_enable  in  1  0 = hold bytes in the FIFO and do not start new transmits.
- ovf_clr  in  1  clears `overflow` and `ovf_count`.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky; a byte was dropped.
- ovf_count  out  8  number of dropped bytes, saturating at 255.

## Operation
- All outputs are registered. After reset, every output is 0 and the FIFO is empty.
- **RX side.** Sample `rx_valid` when the RX holdoff flag is clear.
  - If `rx_valid` is high, pulse `uart_rd` for one cycle.
  - If the FIFO is not full, push `rx_data`. If it is full, drop the byte, set `overflow`, and increment `ovf_count` (saturating at 255).
  - The RX holdoff flag blocks sampling for exactly one cycle after each `uart_rd`, because `rx_valid` falls one cycle late.
- **TX FSM states:**
  - IDLE: if the FIFO is not empty, `tx_enable`=1 and `tx_busy`=0, then:
    - pop the head;
    - set `tx_data` to the transformed byte and pulse `uart_wr`;
    - set `lf_pend` = (mode[1] && head == 0x0D);
    - go to HOLD.
  - HOLD: count TX_HOLDOFF cycles, then go to SEND_LF if `lf_pend` is set, otherwise IDLE.
  - SEND_LF: when `tx_busy`=0, send 0x0A, clear `lf_pend`, and go to HOLD.
    - `tx_enable` is not checked here, so an expansion in progress always completes.
- **Transform.** If mode[0]=1 and the byte is in 0x61–0x7A, subtract 0x20. Otherwise the byte passes through unchanged.
  - `mode` is sampled at pop time and is not latched per byte at push.
- **Simultaneous push and pop.** Both are allowed in one cycle. `fifo_level` stays unchanged, and a push into a full FIFO in the same cycle as a pop succeeds.
- **Pointers.** Read and write pointers are $clog2(DEPTH) bits and wrap naturally. Full and empty are derived from `fifo_level`.
- **`ovf_clr` priority.** `ovf_clr` takes priority over an increment in the same cycle; the count becomes 0, not 1.
- **Reset mid-operation.** Reset mid-operation aborts any transfer. `uart_wr` and `uart_rd` drop immediately (asynchronously), and FIFO contents are discarded.

## Timing
- `rx_valid` first seen high at edge n → `uart_rd`=1 and push during cycle n+1 → `fifo_level` updates at n+1.
- Minimum latency from `rx_valid` to `uart_wr`: 2 cycles, with an empty FIFO, an idle transmitter and `tx_enable`=1.
- Back-to-back transmits are separated by at least TX_HOLDOFF+1 cycles. In practice they are separated by the UART frame time gated by `tx_busy`.
- The RX path sustains one byte every 2 cycles, far above the line rate.

## Structure
- Shared package `uart_pkg`:
  - ASCII constants `CHAR_CR`=0x0D, `CHAR_LF`=0x0A, `CHAR_A_LO`=0x61, `CHAR_Z_LO`=0x7A, `CASE_OFFSET`=0x20;
  - the mode-bit indices;
  - the TX FSM state enum.
- One sub-module, `sync_fifo` (parameters WIDTH, DEPTH), exposing push, pop, din, dout (first-word-fallthrough), full, empty and level. It is reusable by later UART blocks.
- The FSM, transform and overflow logic live in `uart_echo_fifo`.

## Test plan
- **Raw echo.** mode=00; send 0x41, 0x7A → TX sees 0x41, 0x7A in order; `overflow`=0; `fifo_level` returns to 0.
- **Upper-case.** mode=01; send "a{z@" (0x61, 0x7B, 0x7A, 0x40) → TX sees 0x41, 0x7B, 0x5A, 0x40.
- **CRLF expansion.** mode=10; send 0x0D, 0x31 → TX sees 0x0D, 0x0A, 0x31. mode=11 with 0x0D behaves identically.
- **Overflow.** DEPTH=16, `tx_enable`=0; push 20 bytes.
  - Expect `fifo_level`=16, `overflow`=1, `ovf_count`=4, and 20 `uart_rd` pulses.
  - Set `tx_enable`=1 → the first 16 bytes go out in order.
  - Pulse `ovf_clr` → `overflow`=0 and `ovf_count`=0.
- **Holdoff and busy.** Hold `tx_busy` low for 1 cycle after `uart_wr`, then high for 100 cycles → exactly one `uart_wr` per byte, with no write while busy.
- **Reset mid-operation.** Assert reset during SEND_LF with 3 bytes queued → all outputs 0 asynchronously, `fifo_level`=0, and no LF is sent after release.
